// File: rtl/imem_pkg.sv
// Shared fetch-path definitions: default widths, the out-of-range filler
// instruction and the response record that decode consumes.
package imem_pkg;

   localparam int IMEM_DATA_W = 8;
   localparam int IMEM_ADDR_W = 8;

   localparam logic [IMEM_DATA_W-1:0] IMEM_NOP_WORD = '0;

   typedef struct packed {
      logic [IMEM_DATA_W-1:0] instr;
      logic [IMEM_ADDR_W-1:0] addr;
      logic                   err;
   } imem_rsp_t;

endpackage

// File: rtl/imem_rsp_fifo.sv
// Two-entry valid/ready response FIFO with a synchronous flush and async
// active-low reset. Output data is forced to zero while the FIFO is empty.
module imem_rsp_fifo
   import imem_pkg::*;
#(
   parameter type T = imem_rsp_t
) (
   input  logic clk,
   input  logic rst_n,
   input  logic flush_i,
   input  logic push_valid_i,
   output logic push_ready_o,
   input  T     push_data_i,
   output logic pop_valid_o,
   input  logic pop_ready_i,
   output T     pop_data_o
);

   logic [1:0] count_q, count_d;
   logic       rd_ptr_q, rd_ptr_d;
   T           slot_q [2];
   logic       do_push, do_pop, wr_ptr;

   // Ready depends only on held state and flush, never on the pop side.
   assign push_ready_o = rst_n && (count_q < 2'd2) && !flush_i;
   assign pop_valid_o  = (count_q != 2'd0);
   assign do_push      = push_valid_i && push_ready_o;
   assign do_pop       = pop_valid_o && pop_ready_i && !flush_i;
   assign wr_ptr       = rd_ptr_q ^ count_q[0];
   assign pop_data_o   = pop_valid_o ? slot_q[rd_ptr_q] : '0;

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      count_d  = count_q;
      rd_ptr_d = rd_ptr_q;
      if (flush_i) begin
         count_d  = 2'd0;
         rd_ptr_d = 1'b0;
      end else begin
         case ({do_push, do_pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
         endcase
         if (do_pop) rd_ptr_d = ~rd_ptr_q;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q   <= 2'd0;
         rd_ptr_q  <= 1'b0;
         slot_q[0] <= '0;
         slot_q[1] <= '0;
      end else begin
         count_q  <= count_d;
         rd_ptr_q <= rd_ptr_d;
         if (do_push) slot_q[wr_ptr] <= push_data_i;
      end
   end

endmodule

// File: rtl/imem_fetch_buffered.sv
// Instruction memory with a program-load write port, read at the accept edge
// straight into a 2-entry response buffer so fetch can stall without loss.
module imem_fetch_buffered
   import imem_pkg::*;
#(
   parameter int                 DATA_W    = IMEM_DATA_W,
   parameter int                 ADDR_W    = IMEM_ADDR_W,
   parameter int                 DEPTH     = 256,
   parameter string              INIT_FILE = "Rom.mem",
   parameter logic [DATA_W-1:0]  NOP_WORD  = IMEM_NOP_WORD
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_addr,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_instr,
   output logic [ADDR_W-1:0] rsp_addr,
   output logic              rsp_err,
   input  logic              flush,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data
);

   typedef struct packed {
      logic [DATA_W-1:0] instr;
      logic [ADDR_W-1:0] addr;
      logic              err;
   } rsp_t;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic              req_oor, wr_oor;
   logic [DATA_W-1:0] rd_word;
   rsp_t              push_entry, head;

   if (DEPTH >= 2**ADDR_W) begin : g_full_map
      assign req_oor = 1'b0;
      assign wr_oor  = 1'b0;
   end else begin : g_part_map
      assign req_oor = (req_addr >= ADDR_W'(DEPTH));
      assign wr_oor  = (wr_addr >= ADDR_W'(DEPTH));
   end

   // NOTE: the array has no reset; contents survive rst_n and map to RAM.
   always_ff @(posedge clk) begin
      if (wr_en && !wr_oor) mem_q[wr_addr] <= wr_data;
   end

   // The FIFO samples this on the same edge as the write, giving read-first.
   assign rd_word    = req_oor ? NOP_WORD : mem_q[req_addr];
   assign push_entry = '{instr: rd_word, addr: req_addr, err: req_oor};

   imem_rsp_fifo #(.T(rsp_t)) u_rsp_fifo (
      .clk          (clk),
      .rst_n        (rst_n),
      .flush_i      (flush),
      .push_valid_i (req_valid),
      .push_ready_o (req_ready),
      .push_data_i  (push_entry),
      .pop_valid_o  (rsp_valid),
      .pop_ready_i  (rsp_ready),
      .pop_data_o   (head)
   );

   assign rsp_instr = head.instr;
   assign rsp_addr  = head.addr;
   assign rsp_err   = head.err;

endmodule
